// File: rtl/seg_scan_pkg.sv
// Shared constants, scan state encoding and pin-polarity helper for the
// multiplexed seven-segment scanner.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 8;
  localparam int IDX_W      = 3;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Maps a logical "1 = lit/enabled" vector onto the physical pin level.
  function automatic logic [SEG_W-1:0] apply_pol(input logic [SEG_W-1:0] v,
                                                 input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Pattern input and physical display bus of the seven-segment scanner.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic                        en;
  logic [NUM_DIGITS*SEG_W-1:0] seg_i;
  logic [NUM_DIGITS-1:0]       blink_mask;
  logic [SEG_W-1:0]            seg_o;
  logic [NUM_DIGITS-1:0]       dig_o;
  logic                        frame_o;

  modport master (
    output en, seg_i, blink_mask,
    input  seg_o, dig_o, frame_o
  );

  modport slave (
    input  en, seg_i, blink_mask,
    output seg_o, dig_o, frame_o
  );

endinterface

// File: rtl/seg_scan_tick.sv
// Dwell counter: counts cycles spent in the current scan state and pulses tc
// on the last one; clear holds it at zero.
module scan_tick #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;

  assign tc = (cnt_reg == limit);

  // Wrapping at limit keeps the counter from ever overflowing its width.
  always_ff @(posedge clk) begin
    if (rst || clear || tc) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit seven-segment scanner with per-frame pattern snapshot and
// inter-digit blanking. Optional digit blinking under SEG_SCAN_BLINK_EN.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DIG_LIM = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LIM = CNT_W'(BLANK_CYCLES - 1);
  localparam logic POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF = POL_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  scan_state_e      state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  // hold_reg marks "idle, outputs off": the next enabled cycle opens a fresh frame.
  logic             hold_reg, hold_next;
  logic             take_snap;
  logic             tick_clear;
  logic             tick_tc;
  logic [CNT_W-1:0] tick_limit;
  logic             blank_digit;

  logic [SEG_W-1:0] pat_in   [NUM_DIGITS];
  logic [SEG_W-1:0] snap_reg [NUM_DIGITS];
  logic [SEG_W-1:0] snap_sel;
  logic [SEG_W-1:0] seg_log;
  logic [SEG_W-1:0] dig_log_wide;
  logic [SEG_W-1:0] seg_pin;
  logic [SEG_W-1:0] dig_pin_wide;

  logic [SEG_W-1:0]      seg_reg;
  logic [NUM_DIGITS-1:0] dig_reg;
  logic                  frame_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
      assign pat_in[gi] = bus.seg_i[gi*SEG_W +: SEG_W];
    end
  endgenerate

  assign tick_limit = (state_reg == DRIVE) ? DIG_LIM : BLK_LIM;
  assign tick_clear = hold_reg || !bus.en;

  scan_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .limit (tick_limit),
    .tc    (tick_tc)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    take_snap  = 1'b0;
    if (!bus.en) begin
      state_next = BLANK;
      idx_next   = '0;
      hold_next  = 1'b1;
    end else if (hold_reg) begin
      state_next = BLANK;
      idx_next   = '0;
      hold_next  = 1'b0;
      take_snap  = 1'b1;
    end else if (tick_tc) begin
      if (state_reg == BLANK) begin
        state_next = DRIVE;
      end else begin
        state_next = BLANK;
        if (idx_reg == IDX_W'(NUM_DIGITS - 1)) begin
          idx_next  = '0;
          take_snap = 1'b1;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [FC_W-1:0]       frm_cnt_reg, frm_cnt_next;
  logic                  phase_reg, phase_next;
  logic [NUM_DIGITS-1:0] mask_reg, mask_next;

  // frm_cnt counts frames started in the current phase; the phase flips as
  // the frame after BLINK_FRAMES completed ones begins.
  always_comb begin
    frm_cnt_next = frm_cnt_reg;
    phase_next   = phase_reg;
    mask_next    = mask_reg;
    if (take_snap) begin
      mask_next = bus.blink_mask;
      if (frm_cnt_reg == FC_W'(BLINK_FRAMES)) begin
        phase_next   = ~phase_reg;
        frm_cnt_next = FC_W'(1);
      end else begin
        frm_cnt_next = frm_cnt_reg + FC_W'(1);
      end
    end
  end

  assign blank_digit = phase_next && mask_next[idx_next];

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      mask_reg    <= '0;
    end else begin
      frm_cnt_reg <= frm_cnt_next;
      phase_reg   <= phase_next;
      mask_reg    <= mask_next;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^bus.blink_mask;
  assign blank_digit  = 1'b0;
`endif

  // Outputs are computed from the next state so the pins change together
  // with the state and never show a stale digit.
  always_comb begin
    snap_sel     = take_snap ? pat_in[idx_next] : snap_reg[idx_next];
    seg_log      = '0;
    dig_log_wide = '0;
    if (state_next == DRIVE) begin
      dig_log_wide = SEG_W'(1) << idx_next;
      if (!blank_digit) begin
        seg_log = snap_sel;
      end
    end
    seg_pin      = apply_pol(seg_log, POL_LOW);
    dig_pin_wide = apply_pol(dig_log_wide, POL_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BLANK;
      idx_reg   <= '0;
      hold_reg  <= 1'b1;
      snap_reg  <= '{default: '0};
      seg_reg   <= SEG_OFF;
      dig_reg   <= DIG_OFF;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
      if (take_snap) begin
        snap_reg <= pat_in;
      end
      seg_reg   <= seg_pin;
      dig_reg   <= dig_pin_wide[NUM_DIGITS-1:0];
      frame_reg <= take_snap;
    end
  end

  assign bus.seg_o   = seg_reg;
  assign bus.dig_o   = dig_reg;
  assign bus.frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (DIGIT=4, BLANK=1, active-low, BLINK_FRAMES=2);
// blink expectations follow SEG_SCAN_BLINK_EN.
module tb_seg_scan;

`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if bus();

  seg_scan #(
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (1),
    .ACTIVE_LOW   (1),
    .BLINK_FRAMES (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total = 0;
  int         bad   = 0;
  bit         mon_on = 1'b0;
  logic [7:0] exp_pat [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected pins for cycle c of a run starting at a fresh frame: each slot is
  // one blank cycle then four drive cycles, six slots per 30-cycle frame.
  task automatic chk_cycle(input string tag, input int c, input bit blink_on);
    int         p, d, f;
    logic [7:0] s;
    logic [5:0] dg;
    logic       fr;
    p = c % 5;
    d = (c / 5) % 6;
    f = c / 30;
    if (p == 0) begin
      dg = 6'h3F;
      s  = 8'hFF;
      fr = (d == 0);
    end else begin
      dg = 6'h3F ^ (6'h01 << d);
      s  = ~exp_pat[d];
      fr = 1'b0;
      if (blink_on && d == 0 && (f % 4) >= 2) s = 8'hFF;
    end
    chk({tag, "_dig"},   32'(bus.dig_o),   32'(dg));
    chk({tag, "_seg"},   32'(bus.seg_o),   32'(s));
    chk({tag, "_frame"}, 32'(bus.frame_o), 32'(fr));
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_dig"},   32'(bus.dig_o),   32'h3F);
    chk({tag, "_seg"},   32'(bus.seg_o),   32'hFF);
    chk({tag, "_frame"}, 32'(bus.frame_o), 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("onehot", 32'($countones(~bus.dig_o) <= 1), 32'd1);
      if (bus.dig_o == 6'h3F) chk("off_seg", 32'(bus.seg_o), 32'hFF);
    end
  end

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.blink_mask = 6'h00;
    for (int k = 0; k < 6; k++) begin
      exp_pat[k]          = 8'h10 + 8'(k);
      bus.seg_i[8*k +: 8] = 8'h10 + 8'(k);
    end
    repeat (3) @(negedge clk);
    chk_off("reset");
    $display("reset state checked");

    mon_on = 1'b1;
    rst    = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      chk_cycle("scan", c, 1'b0);
      if (c == 3)  bus.seg_i[7:0] = 8'hFF;
      if (c == 29) exp_pat[0] = 8'hFF;
    end
    $display("scan and snapshot: 48 cycles checked");

    bus.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_off("en_low");
    end
    $display("en low: display blanked");

    bus.en = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk_cycle("en_rise", c, 1'b0);
    end
    $display("en rise: fresh frame checked");

    rst            = 1'b1;
    bus.seg_i[7:0] = 8'h10;
    exp_pat[0]     = 8'h10;
    bus.blink_mask = 6'b000001;
    @(negedge clk);
    chk_off("rst_mid");
    rst = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      chk_cycle("after_rst", c, BLINK_BUILD);
    end
    $display("mid-dwell reset and blink frames checked (blink build=%0d)", BLINK_BUILD);

    repeat (800) @(negedge clk);
    $display("free-run invariant window done");
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
